// File: rtl/act_skew_feeder.sv
// Activation skew feeder: accepts N-lane activation beats and presents them diagonally
// skewed (lane i delayed i advances), then zero-flushes the skew and pulses tile_done.
module act_skew_feeder #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 8,
   parameter int unsigned KW = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [N*DW-1:0] in_data_i,
   input  logic            in_last_i,
   output logic [N*DW-1:0] a_out_o,
   output logic [N-1:0]    a_vld_o,
   output logic            fire_o,
   output logic            busy_o,
   output logic            tile_done_o,
   output logic [KW-1:0]   beat_cnt_o
);

   localparam int unsigned FW = (N > 2) ? $clog2(N - 1) : 1;
   localparam logic [FW-1:0] FlushLast = FW'((N > 1) ? (N - 2) : 0);

   typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

   state_e        state_q, state_d;
   logic [FW-1:0] flush_q, flush_d;
   logic [KW-1:0] beat_q, beat_d;
   logic          done_q, done_d;
   logic          fire_q;
   logic          accept, adv, flushing;

   assign flushing   = (state_q == StFlush);
   assign in_ready_o = !flushing;
   assign accept     = in_valid_i && !flushing;
   assign adv        = accept || flushing;

   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      beat_d  = beat_q;
      done_d  = 1'b0;
      if (accept) begin
         // First beat of a tile restarts the count; later beats saturate at all-ones.
         if (state_q == StIdle)  beat_d = KW'(1);
         else if (!(&beat_q))    beat_d = beat_q + KW'(1);
      end
      unique case (state_q)
         StIdle, StStream: begin
            if (accept) begin
               if (in_last_i) begin
                  if (N > 1) begin
                     state_d = StFlush;
                     flush_d = '0;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = StStream;
               end
            end
         end
         StFlush: begin
            if (flush_q == FlushLast) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               flush_d = flush_q + FW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         flush_q <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         fire_q  <= adv;
      end
   end

   // Lane i is a depth-(i+1) chain; its last stage drives the PE row directly.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] data_q [i+1];
      logic [i:0]    vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s <= i; s++) data_q[s] <= '0;
            vld_q <= '0;
         end else if (adv) begin
            data_q[0] <= flushing ? '0 : in_data_i[i*DW +: DW];
            vld_q[0]  <= !flushing;
            for (int s = 1; s <= i; s++) begin
               data_q[s] <= data_q[s-1];
               vld_q[s]  <= vld_q[s-1];
            end
         end
      end

      assign a_out_o[i*DW +: DW] = data_q[i];
      assign a_vld_o[i]          = vld_q[i];
   end

   assign fire_o      = fire_q;
   assign busy_o      = (state_q != StIdle);
   assign tile_done_o = done_q;
   assign beat_cnt_o  = beat_q;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (N=4, DW=8): skew timing, stalls, back-to-back
// tiles, flush back-pressure and reset during flush.
module tb_act_skew_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [31:0] a_out;
   logic [3:0]  a_vld;
   logic        fire;
   logic        busy;
   logic        tile_done;
   logic [7:0]  beat_cnt;

   int checks   = 0;
   int failures = 0;

   act_skew_feeder #(.N(4), .DW(8), .KW(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .a_out_o     (a_out),
      .a_vld_o     (a_vld),
      .fire_o      (fire),
      .busy_o      (busy),
      .tile_done_o (tile_done),
      .beat_cnt_o  (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat k, lane i = 16*(k+1)+i.
   logic [31:0] beats [3] = '{32'h13121110, 32'h23222120, 32'h33323130};
   // Lane i shows beat (t-i) after the t-th advance, zero once flushed.
   logic [31:0] exp_a [6] = '{32'h00000010, 32'h00001120, 32'h00122130,
                              32'h13223100, 32'h23320000, 32'h33000000};
   logic [3:0]  exp_v [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
   logic [5:0]  exp_rdy   = 6'b100011;

   int waited;
   int done_seen;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      tick();
      tick();
      chk("rst_a_out", a_out, 0);
      chk("rst_a_vld", a_vld, 0);
      chk("rst_fire", fire, 0);
      chk("rst_tile_done", tile_done, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_fire", fire, 0);
         chk("idle_busy", busy, 0);
         chk("idle_a_out", a_out, 0);
         chk("idle_in_ready", in_ready, 1);
      end

      // 3-beat tile; in_valid held high with junk during flush must not be accepted.
      for (int t = 0; t < 6; t++) begin
         in_valid = (t < 5);
         in_data  = (t < 3) ? beats[t] : 32'hFFFFFFFF;
         in_last  = (t == 2);
         tick();
         chk("s3_a_out", a_out, exp_a[t]);
         chk("s3_a_vld", a_vld, exp_v[t]);
         chk("s3_fire", fire, 1);
         chk("s3_in_ready", in_ready, exp_rdy[t]);
         chk("s3_tile_done", tile_done, (t == 5));
      end
      in_valid = 1'b0;
      chk("s3_beat_cnt", beat_cnt, 3);
      chk("s3_busy_end", busy, 0);
      tick();
      chk("s3_post_fire", fire, 0);
      chk("s3_post_done", tile_done, 0);
      chk("s3_hold_a_out", a_out, 32'h33000000);
      chk("s3_hold_cnt", beat_cnt, 3);

      // Stall mid-tile: pipeline freezes, nothing lost.
      in_valid = 1'b1;
      in_data  = beats[0];
      in_last  = 1'b0;
      tick();
      chk("st_a_out0", a_out, 32'h00000010);
      chk("st_a_vld0", a_vld, 4'b0001);
      chk("st_cnt0", beat_cnt, 1);
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("st_stall_fire", fire, 0);
         chk("st_stall_a_out", a_out, 32'h00000010);
         chk("st_stall_a_vld", a_vld, 4'b0001);
         chk("st_stall_busy", busy, 1);
      end
      in_valid = 1'b1;
      in_data  = beats[1];
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("st_a_out1", a_out, 32'h00001120);
      chk("st_a_vld1", a_vld, 4'b0011);
      chk("st_fire1", fire, 1);
      chk("st_cnt1", beat_cnt, 2);
      waited = 0;
      while (!tile_done && waited < 10) begin
         tick();
         waited++;
      end
      chk("st_flush_len", waited, 3);
      chk("st_final_a_out", a_out, 32'h23000000);
      chk("st_final_a_vld", a_vld, 4'b1000);

      // Single-beat tile, then a new tile starting in the tile_done cycle.
      in_valid = 1'b1;
      in_data  = beats[0];
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("sb_busy", busy, 1);
      chk("sb_in_ready", in_ready, 0);
      chk("sb_lane0", a_out[7:0], 8'h10);
      chk("sb_cnt", beat_cnt, 1);
      tick();
      tick();
      chk("sb_done_early", tile_done, 0);
      tick();
      chk("sb_done", tile_done, 1);
      chk("sb_done_ready", in_ready, 1);
      chk("sb_done_busy", busy, 0);
      chk("sb_done_lane3", a_out, 32'h13000000);
      in_valid = 1'b1;
      in_data  = 32'h43424140;
      tick();
      in_valid = 1'b0;
      chk("nt_cnt", beat_cnt, 1);
      chk("nt_busy", busy, 1);
      chk("nt_done", tile_done, 0);
      chk("nt_a_out", a_out, 32'h00000040);
      chk("nt_a_vld", a_vld, 4'b0001);

      // Reset asserted during flush.
      in_valid = 1'b1;
      in_data  = 32'h53525150;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("rf_in_flush", in_ready, 0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rf_a_out", a_out, 0);
      chk("rf_a_vld", a_vld, 0);
      chk("rf_fire", fire, 0);
      chk("rf_busy", busy, 0);
      chk("rf_cnt", beat_cnt, 0);
      tick();
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (tile_done) done_seen++;
      end
      chk("rf_no_done", done_seen, 0);
      chk("rf_ready", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
